// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks EX/MEM/WB occupancy, selects ALU forwarding,
// stalls on load-use and multi-cycle mul/div, and flushes on EX redirects.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_wen,
  input  logic        id_is_load,
  input  logic        id_is_muldiv,
  input  logic        ex_redirect,
  input  logic        md_done,
  output logic        stall,
  output logic        ex_hold,
  output logic        ex_bubble,
  output logic        mem_bubble,
  output logic        flush_ifid,
  output logic [1:0]  forwardA,
  output logic [1:0]  forwardB,
  output logic        md_start,
  output logic [31:0] stall_cnt
);

  typedef enum logic {RUN, MD_WAIT} state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_wen;
    logic       is_load;
    logic       is_muldiv;
  } slot_t;

  state_t     state_q, state_d;
  slot_t      ex_q, mem_q, wb_q;
  slot_t      id_slot, mem_next;
  logic [4:0] ex_rs1_q, ex_rs2_q;
  logic       ex_rs1_used_q, ex_rs2_used_q;
  logic       load_use;

  // WB only feeds forwarding; its class bits are tracked but have no consumer.
  logic unused_wb_class;
  assign unused_wb_class = wb_q.is_load ^ wb_q.is_muldiv;

  function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] rs,
                                         input slot_t mem, input slot_t wb);
    if (used && mem.valid && mem.reg_wen && mem.rd == rs && mem.rd != 5'd0)
      return 2'b10;
    else if (used && wb.valid && wb.reg_wen && wb.rd == rs && wb.rd != 5'd0)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    forwardA = fwd_sel(ex_rs1_used_q, ex_rs1_q, mem_q, wb_q);
    forwardB = fwd_sel(ex_rs2_used_q, ex_rs2_q, mem_q, wb_q);
  end

  always_comb begin
    load_use = id_valid && ex_q.valid && ex_q.is_load && ex_q.rd != 5'd0 &&
               ((id_rs1_used && id_rs1 == ex_q.rd) ||
                (id_rs2_used && id_rs2 == ex_q.rd));
  end

  // Priority in RUN: redirect, then mul/div start, then load-use.
  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    ex_hold    = 1'b0;
    ex_bubble  = 1'b0;
    mem_bubble = 1'b0;
    flush_ifid = 1'b0;
    md_start   = 1'b0;
    case (state_q)
      RUN: begin
        if (ex_redirect) begin
          flush_ifid = 1'b1;
          ex_bubble  = 1'b1;
        end else if (ex_q.valid && ex_q.is_muldiv) begin
          md_start   = 1'b1;
          stall      = 1'b1;
          ex_hold    = 1'b1;
          mem_bubble = 1'b1;
          state_d    = MD_WAIT;
        end else if (load_use) begin
          stall     = 1'b1;
          ex_bubble = 1'b1;
        end
      end
      MD_WAIT: begin
        if (md_done) begin
          state_d = RUN;
        end else begin
          stall      = 1'b1;
          ex_hold    = 1'b1;
          mem_bubble = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    id_slot.valid     = id_valid && !ex_bubble;
    id_slot.rd        = id_rd;
    id_slot.reg_wen   = id_reg_wen;
    id_slot.is_load   = id_is_load;
    id_slot.is_muldiv = id_is_muldiv;
    mem_next          = ex_q;
    mem_next.valid    = ex_q.valid && !mem_bubble && !ex_hold;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      ex_q          <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_rs1_used_q <= 1'b0;
      ex_rs2_used_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_next;
      wb_q    <= mem_q;
      if (!ex_hold) begin
        ex_q          <= id_slot;
        ex_rs1_q      <= id_rs1;
        ex_rs2_q      <= id_rs2;
        ex_rs1_used_q <= id_rs1_used;
        ex_rs2_used_q <= id_rs2_used;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall && stall_cnt != '1)
      stall_cnt <= stall_cnt + 32'd1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: forwarding, load-use, mul/div wait,
// redirect priority, reset in MD_WAIT and stall counter saturation.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rs1_used, id_rs2_used, id_reg_wen, id_is_load, id_is_muldiv;
  logic        ex_redirect, md_done;
  logic        stall, ex_hold, ex_bubble, mem_bubble, flush_ifid, md_start;
  logic [1:0]  forwardA, forwardB;
  logic [31:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  hazard_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .id_rd        (id_rd),
    .id_reg_wen   (id_reg_wen),
    .id_is_load   (id_is_load),
    .id_is_muldiv (id_is_muldiv),
    .ex_redirect  (ex_redirect),
    .md_done      (md_done),
    .stall        (stall),
    .ex_hold      (ex_hold),
    .ex_bubble    (ex_bubble),
    .mem_bubble   (mem_bubble),
    .flush_ifid   (flush_ifid),
    .forwardA     (forwardA),
    .forwardB     (forwardB),
    .md_start     (md_start),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic id_set(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic wen, input logic ld, input logic md);
    id_valid     = v;
    id_rs1       = rs1;
    id_rs1_used  = u1;
    id_rs2       = rs2;
    id_rs2_used  = u2;
    id_rd        = rd;
    id_reg_wen   = wen;
    id_is_load   = ld;
    id_is_muldiv = md;
  endtask

  task automatic id_nop();
    id_set(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [9:0] out_bundle();
    return {stall, ex_hold, ex_bubble, mem_bubble, flush_ifid,
            forwardA, forwardB, md_start};
  endfunction

  initial begin
    int stall_hi;
    int start_hi;
    logic stall_on_done;

    rst = 1'b1;
    ex_redirect = 1'b0;
    md_done = 1'b0;
    id_nop();
    tick();
    tick();
    rst = 1'b0;
    settle();
    check("reset_outputs", 32'(out_bundle()), 32'd0);
    check("reset_stall_cnt", stall_cnt, 32'd0);

    // Forwarding: MEM priority, WB only, x0 never forwarded
    id_set(1, 5'd1, 1, 5'd2, 0, 5'd5, 1, 0, 0); tick();
    id_set(1, 5'd1, 1, 5'd2, 0, 5'd5, 1, 0, 0); tick();
    id_set(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0); tick();
    id_set(1, 5'd5, 1, 5'd6, 1, 5'd7, 1, 0, 0); settle();
    check("fwdA_mem_over_wb", 32'(forwardA), 32'h2);
    check("fwdB_unused_src", 32'(forwardB), 32'h0);
    check("no_stall_alu", 32'(stall), 32'h0);
    tick();
    id_set(1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0); settle();
    check("fwdA_wb_only", 32'(forwardA), 32'h1);
    check("fwdB_mem", 32'(forwardB), 32'h2);
    tick();
    id_set(1, 5'd0, 1, 5'd0, 1, 5'd8, 1, 0, 0); tick();
    id_nop(); settle();
    check("fwdA_x0", 32'(forwardA), 32'h0);
    check("fwdB_x0", 32'(forwardB), 32'h0);

    // Load-use: lw x7 then add reading x7 via rs2
    id_set(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 1, 0); tick();
    id_set(1, 5'd3, 1, 5'd7, 1, 5'd9, 1, 0, 0); settle();
    check("lu_stall", 32'(stall), 32'h1);
    check("lu_ex_bubble", 32'(ex_bubble), 32'h1);
    check("lu_ex_hold", 32'(ex_hold), 32'h0);
    tick(); settle();
    check("lu_stall_one_cycle", 32'(stall), 32'h0);
    check("lu_bubble_one_cycle", 32'(ex_bubble), 32'h0);
    tick();
    id_nop(); settle();
    check("lu_fwdB_wb", 32'(forwardB), 32'h1);
    check("lu_fwdA", 32'(forwardA), 32'h0);
    check("lu_stall_cnt", stall_cnt, 32'd1);

    // Mul/div: md_done four cycles after md_start
    id_set(1, 5'd1, 1, 5'd2, 1, 5'd10, 1, 0, 1); tick();
    id_nop();
    stall_hi = 0;
    start_hi = 0;
    stall_on_done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      md_done = (i == 4);
      settle();
      if (i == 0) begin
        check("md_start_hold", 32'(ex_hold), 32'h1);
        check("md_start_mem_bubble", 32'(mem_bubble), 32'h1);
      end
      stall_hi += int'(stall);
      start_hi += int'(md_start);
      if (i == 4) stall_on_done = stall;
      tick();
    end
    md_done = 1'b0;
    check("md_stall_cycles", 32'(stall_hi), 32'd4);
    check("md_start_pulses", 32'(start_hi), 32'd1);
    check("md_stall_on_done", 32'(stall_on_done), 32'h0);
    settle();
    check("md_back_to_run", 32'(out_bundle()), 32'd0);
    check("md_stall_cnt", stall_cnt, 32'd5);

    // Redirect beats load-use in the same cycle
    id_set(1, 5'd1, 1, 5'd0, 0, 5'd12, 1, 1, 0); tick();
    id_set(1, 5'd12, 1, 5'd0, 0, 5'd13, 1, 0, 0);
    ex_redirect = 1'b1; settle();
    check("rd_flush", 32'(flush_ifid), 32'h1);
    check("rd_ex_bubble", 32'(ex_bubble), 32'h1);
    check("rd_stall", 32'(stall), 32'h0);
    check("rd_ex_hold", 32'(ex_hold), 32'h0);
    tick();
    ex_redirect = 1'b0;
    id_nop(); settle();
    check("rd_stall_cnt", stall_cnt, 32'd5);

    // Redirect beats mul/div start
    id_set(1, 5'd1, 1, 5'd2, 1, 5'd11, 1, 0, 1); tick();
    id_nop();
    ex_redirect = 1'b1; settle();
    check("rd_md_start", 32'(md_start), 32'h0);
    check("rd_md_stall", 32'(stall), 32'h0);
    tick();
    ex_redirect = 1'b0;

    // No hazard from an invalid ID slot
    id_set(1, 5'd1, 1, 5'd0, 0, 5'd13, 1, 1, 0); tick();
    id_set(0, 5'd13, 1, 5'd13, 1, 5'd14, 1, 0, 0); settle();
    check("idv0_no_stall", 32'(stall), 32'h0);
    tick();

    // Reset while in MD_WAIT
    id_set(1, 5'd1, 1, 5'd2, 1, 5'd14, 1, 0, 1); tick();
    id_nop(); settle();
    check("rst_md_start", 32'(md_start), 32'h1);
    tick(); settle();
    check("wait_stall", 32'(stall), 32'h1);
    check("wait_no_restart", 32'(md_start), 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0; settle();
    check("rst_wait_outputs", 32'(out_bundle()), 32'd0);
    check("rst_wait_cnt", stall_cnt, 32'd0);
    md_done = 1'b1; settle();
    check("stray_done_outputs", 32'(out_bundle()), 32'd0);
    tick();
    md_done = 1'b0; settle();
    check("after_stray_outputs", 32'(out_bundle()), 32'd0);
    check("after_stray_cnt", stall_cnt, 32'd0);

    // Counter saturation from a preloaded value
    id_set(1, 5'd1, 1, 5'd2, 1, 5'd15, 1, 0, 1);
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    tick();
    id_nop();
    for (int i = 0; i < 4; i++) begin
      md_done = (i == 3);
      settle();
      tick();
    end
    md_done = 1'b0; settle();
    check("cnt_saturate", stall_cnt, 32'hFFFF_FFFF);
    check("cnt_sat_idle", 32'(stall), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
